// File: rtl/serial_adder_pkg.sv
//==============================================================================
// serial_adder_pkg
// Shared types and limits for the bit-serial adder.
// Revision: 1.0
//==============================================================================
`default_nettype none

package serial_adder_pkg;

   localparam int WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_if.sv
//==============================================================================
// serial_adder_if
// Operand/result handshake bundle; sub exists only with SERIAL_ADDER_SUB_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (output start, a, b, cin, sub,
                   input  busy, done, sum, cout, overflow);
   modport slave  (input  start, a, b, cin, sub,
                   output busy, done, sum, cout, overflow);
`else
   modport master (output start, a, b, cin,
                   input  busy, done, sum, cout, overflow);
   modport slave  (input  start, a, b, cin,
                   output busy, done, sum, cout, overflow);
`endif

endinterface : serial_adder_if

`default_nettype wire

// File: rtl/full_adder_1b.sv
//==============================================================================
// full_adder_1b
// Combinational single-bit full adder slice.
// Revision: 1.0
//==============================================================================
`default_nettype none

module full_adder_1b (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder_1b

`default_nettype wire

// File: rtl/serial_adder.sv
//==============================================================================
// serial_adder
// LSB-first bit-serial adder, one bit per clock; SERIAL_ADDER_SUB_EN adds a-b.
// Revision: 1.0
//==============================================================================
`default_nettype none

module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   sa_q;
   logic [WIDTH-1:0]   sb_q;
   logic [WIDTH-1:0]   sr_q;
   logic [WIDTH-1:0]   sum_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q;
   logic               cout_q;
   logic               ovf_q;
   logic               busy_q;
   logic               done_q;

   logic               fa_s;
   logic               carry_d;
   logic [WIDTH-1:0]   sr_d;
   logic [WIDTH-1:0]   sb_load_d;
   logic               carry_load_d;

   full_adder_1b u_fa (
      .a  (sa_q[0]),
      .b  (sb_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (carry_d)
   );

   assign sr_d = {fa_s, sr_q[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is a + ~b + 1; the forced carry-in replaces cin.
   assign sb_load_d    = bus.sub ? ~bus.b : bus.b;
   assign carry_load_d = bus.sub ? 1'b1   : bus.cin;
`else
   assign sb_load_d    = bus.b;
   assign carry_load_d = bus.cin;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sr_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  sa_q    <= bus.a;
                  sb_q    <= sb_load_d;
                  carry_q <= carry_load_d;
                  sr_q    <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               sa_q    <= sa_q >> 1;
               sb_q    <= sb_q >> 1;
               sr_q    <= sr_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  // carry_q here is the carry into the MSB slice.
                  sum_q   <= sr_d;
                  cout_q  <= carry_d;
                  ovf_q   <= carry_q ^ carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
//==============================================================================
// tb_serial_adder
// Directed self-checking bench for serial_adder at WIDTH=8.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_serial_adder;

   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start one operation, wait for done, and check timing plus results.
   task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic icin, input logic [7:0] es, input logic ec,
                         input logic eo);
      int t;
      int nb;
      bus.a     = ia;
      bus.b     = ib;
      bus.cin   = icin;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      t  = 0;
      nb = 0;
      while (!bus.done && t < 20) begin
         if (bus.busy) nb++;
         tick();
         t++;
      end
      check({tag, "_latency"}, t, 8);
      check({tag, "_busy_cycles"}, nb, 8);
      check({tag, "_sum"}, {24'd0, bus.sum}, {24'd0, es});
      check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
      check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
      tick();
      check({tag, "_done_width"}, {31'd0, bus.done}, 32'd0);
   endtask

   logic [7:0] ca [4];
   logic [7:0] cb [4];
   logic       cc [4];
   logic [7:0] cs [4];
   logic       cco[4];
   logic       cov[4];

   initial begin
      int t;
      int ndone;
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub   = 1'b0;
`endif
      tick();
      tick();
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_sum", {24'd0, bus.sum}, 32'd0);
      check("rst_cout", {31'd0, bus.cout}, 32'd0);
      check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      rst_n = 1'b1;
      tick();

      run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("add_7f_cin", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
      bus.sub = 1'b1;
      run_op("sub_10_20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
      run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      bus.sub = 1'b0;
`endif

      // start pulsed mid-operation must not disturb the running add
      bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      t = 0;
      while (!bus.done && t < 20) begin
         if (t == 2) begin
            bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         t++;
      end
      bus.start = 1'b0;
      check("ign_latency", t, 8);
      check("ign_sum", {24'd0, bus.sum}, 32'h46);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done) ndone++;
      end
      check("ign_extra_done", ndone, 0);

      // start held high: back-to-back operations every WIDTH+1 cycles
      ca[0] = 8'h01; cb[0] = 8'h02; cc[0] = 1'b0; cs[0] = 8'h03; cco[0] = 1'b0; cov[0] = 1'b0;
      ca[1] = 8'h80; cb[1] = 8'h80; cc[1] = 1'b1; cs[1] = 8'h01; cco[1] = 1'b1; cov[1] = 1'b1;
      ca[2] = 8'h0F; cb[2] = 8'hF0; cc[2] = 1'b1; cs[2] = 8'h00; cco[2] = 1'b1; cov[2] = 1'b0;
      ca[3] = 8'h64; cb[3] = 8'h64; cc[3] = 1'b0; cs[3] = 8'hC8; cco[3] = 1'b0; cov[3] = 1'b1;
      bus.a = ca[0]; bus.b = cb[0]; bus.cin = cc[0]; bus.start = 1'b1;
      tick();
      bus.a = ca[1]; bus.b = cb[1]; bus.cin = cc[1];
      t = 0;
      for (int i = 0; i < 4; i++) begin
         while (!bus.done && t < 20) begin
            tick();
            t++;
         end
         check($sformatf("b2b%0d_gap", i), t, (i == 0) ? 8 : 9);
         check($sformatf("b2b%0d_sum", i), {24'd0, bus.sum}, {24'd0, cs[i]});
         check($sformatf("b2b%0d_cout", i), {31'd0, bus.cout}, {31'd0, cco[i]});
         check($sformatf("b2b%0d_ovf", i), {31'd0, bus.overflow}, {31'd0, cov[i]});
         if (i < 3) begin
            tick();
            t = 1;
            if (i + 2 < 4) begin
               bus.a = ca[i+2]; bus.b = cb[i+2]; bus.cin = cc[i+2];
            end
         end
      end
      bus.start = 1'b0;
      tick();

      // reset in the middle of an operation aborts it
      bus.a = 8'h21; bus.b = 8'h10; bus.cin = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      check("abort_sum", {24'd0, bus.sum}, 32'd0);
      check("abort_ovf", {31'd0, bus.overflow}, 32'd0);
      run_op("post_rst", 8'h21, 8'h10, 1'b1, 8'h32, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_serial_adder

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder that succeeds the single-bit full-adder tile. It adds two WIDTH-bit operands, one bit per clock, LSB first, through one registered full-adder slice. A start/busy/done handshake frames each operation. It sits behind the top-level wrapper: operands and control come from ui_in/uio_in, and results go to uo_out/uio_out.

## Interface
- WIDTH, default 8: operand and result width. Legal range is 2..32.
- CNT_W, default $clog2(WIDTH): bit-counter width. Derived only; never overridden.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset. Synchronous and active-low: sampled on the clk rising edge, and it clears all state.
- start  input  1  request a new operation. Sampled only in IDLE or DONE.
- a  input  WIDTH  operand A. Captured on the accepted start edge.
- b  input  WIDTH  operand B. Captured on the accepted start edge.
- cin  input  1  carry-in. Captured on the accepted start edge.
- sub  input  1  subtract mode. Present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result. Held until the next accepted start.
- cout  output  1  carry-out of the MSB. In subtract mode, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, go to RUN. Otherwise stay.
  - RUN: after WIDTH bit steps, go to DONE.
  - DONE: if start=1, go directly to RUN (back-to-back). Otherwise go to IDLE.
- Accepted start, in IDLE or DONE:
  - Load a into shift register SA and b into shift register SB.
  - Load the carry flop with cin.
  - Clear the bit counter and the result shift register SR.
- RUN, each cycle:
  - s = SA[0] ^ SB[0] ^ carry.
  - carry <= maj(SA[0], SB[0], carry).
  - SA and SB shift right by one.
  - SR shifts right with s entering at the MSB.
  - The counter increments. When counter == WIDTH-1, the step is the last one.
- Overflow rule: overflow = carry into the MSB XOR carry out of the MSB. Capture the carry into the MSB on the last step.
- On the RUN->DONE edge:
  - sum <= final SR.
  - cout <= final carry.
  - overflow is updated.
- start while busy=1 is ignored. No queueing and no error flag.
- Arithmetic wraps modulo 2^WIDTH. Carries outside the WIDTH bits appear only on cout.
- Reset (rst_n=0 at an edge) aborts any operation in progress and forces the following:
  - state=IDLE.
  - busy=0, done=0.
  - sum=0, cout=0, overflow=0.
  - counter, carry flop and all shift registers = 0.

## Timing
- Start accepted at edge k.
- busy=1 from cycle k+1 through k+WIDTH.
- done=1 for the single cycle k+WIDTH+1. sum, cout and overflow are valid from that cycle onward.
- Latency is WIDTH+1 cycles from start to done.
- Throughput is one operation per WIDTH+1 cycles when start is held high continuously.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN, defined:
  - The sub port exists and is captured on start.
  - When sub=1, SB loads ~b and the carry flop loads 1, giving a - b. cin is ignored.
- SERIAL_ADDER_SUB_EN, undefined:
  - The sub port is absent.
  - The block performs addition only (a + b + cin).

## Structure
- Shared package serial_adder_pkg contains:
  - the FSM state enum (IDLE, RUN, DONE);
  - WIDTH_MAX = 32.
- Sub-module full_adder_1b: purely combinational. Ports a, b, ci, s, co. Instantiated once inside serial_adder.
- Top-level glue stays in the wrapper. serial_adder has no pad knowledge.

## Test plan
All scenarios use WIDTH=8.
- a=0x5A, b=0x33, cin=0 → sum=0x8D, cout=0, overflow=1. done pulses exactly at k+9; busy is high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x00, cin=1 → sum=0x80, overflow=1.
- SERIAL_ADDER_SUB_EN defined, sub=1:
  - a=0x10, b=0x20 → sum=0xF0, cout=0, overflow=0.
  - a=0x80, b=0x01 → sum=0x7F, overflow=1.
- start pulsed at k+3 with different operands while busy → ignored. The first result is unchanged and no extra done pulse occurs.
- rst_n=0 for one cycle at k+4 → next cycle busy=0, done=0, sum=0. A new start afterwards completes normally.
- start held high continuously → done pulses every 9 cycles, with each result matching the operands presented at the corresponding accept edge.
